median_window_3x3: RTL and testbench

Parametrised 3x3 pixel-window generator that feeds the median filter core. It accepts a raster-order pixel stream and keeps two line buffers plus a 3x3 array of clock-enabled window registers. For every accepted pixel whose full 3x3 neighbourhood lies inside the frame, it presents the nine neighbourhood pixels with a one-cycle valid pulse. It supersedes the single clock-enabled register stage with a depth-, width- and geometry-parametrised buffer.

---
 rtl/median_pkg.sv | 14 +
 rtl/line_buffer_median.sv | 25 ++
 rtl/median_ce_reg.sv | 32 +++
 rtl/median_window_3x3.sv | 108 ++++++++++
 tb/tb_median_window_3x3.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the 3x3 median window generator and the median core:
// window geometry, centre tap index and the tap-to-bit-offset mapping.
package median_pkg;

  localparam int WIN_DIM    = 3;
  localparam int WIN_TAPS   = 9;
  localparam int CENTRE_TAP = 4;

  // Tap (r,c) lives at bits [(3r+c)*width +: width] of the flattened window.
  function automatic int tap_offset(input int r, input int c, input int width);
    return (WIN_DIM * r + c) * width;
  endfunction

endpackage

// File: rtl/line_buffer_median.sv
// Single-port read-first line RAM: rd_data shows the old word while the same
// address is written on the edge, so a line can be shifted into the next one.
module line_buffer_median #(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640
) (
  input  logic                        clk,
  input  logic                        we,
  input  logic [$clog2(LINE_LEN)-1:0] addr,
  input  logic [WIDTH-1:0]            wr_data,
  output logic [WIDTH-1:0]            rd_data
);

  logic [WIDTH-1:0] mem [LINE_LEN];

  // Contents are intentionally not reset; the row counter masks stale data.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

  assign rd_data = mem[addr];

endmodule

// File: rtl/median_ce_reg.sv
// Clock-enabled register with synchronous active-high reset; one window tap.
module median_ce_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ce) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/median_window_3x3.sv
// 3x3 pixel-window generator: two line buffers plus nine window registers,
// emitting a one-cycle valid pulse for every fully-inside neighbourhood.
module median_window_3x3
  import median_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LINE_LEN = 640
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sof,
  input  logic [WIDTH-1:0]        in_data,
  output logic                    out_valid,
  output logic [WIN_TAPS*WIDTH-1:0] out_win
);

  localparam int              CW       = $clog2(LINE_LEN);
  localparam logic [CW-1:0]   LAST_COL = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0]   MIN_COL  = CW'(2);
  localparam logic [1:0]      LAST_ROW = 2'd2;

  logic [CW-1:0]    col_q, col_d, col_cur;
  logic [1:0]       row_q, row_d, row_cur;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic [WIDTH-1:0] p1, p2;
  logic [WIDTH-1:0] win_q [WIN_DIM][WIN_DIM];

  // Reset wins over a pixel presented in the same cycle.
  assign accept = in_valid & ~rst;

  // A start-of-frame pixel is always treated as (row 0, col 0).
  always_comb begin
    col_cur     = in_sof ? '0 : col_q;
    row_cur     = in_sof ? '0 : row_q;
    col_d       = col_q;
    row_d       = row_q;
    out_valid_d = 1'b0;
    if (in_valid) begin
      out_valid_d = (row_cur == LAST_ROW) && (col_cur >= MIN_COL);
      if (col_cur == LAST_COL) begin
        col_d = '0;
        row_d = (row_cur == LAST_ROW) ? LAST_ROW : row_cur + 2'd1;
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;

  line_buffer_median #(.WIDTH(WIDTH), .LINE_LEN(LINE_LEN)) u_lb0 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_cur),
    .wr_data (in_data),
    .rd_data (p1)
  );

  line_buffer_median #(.WIDTH(WIDTH), .LINE_LEN(LINE_LEN)) u_lb1 (
    .clk     (clk),
    .we      (accept),
    .addr    (col_cur),
    .wr_data (p1),
    .rd_data (p2)
  );

  // Columns shift left on each accept; the new right column is (p2, p1, in_data).
  for (genvar r = 0; r < WIN_DIM; r++) begin : g_row
    for (genvar c = 0; c < WIN_DIM; c++) begin : g_col
      logic [WIDTH-1:0] tap_d;
      if (c < WIN_DIM - 1) begin : g_shift
        assign tap_d = win_q[r][c+1];
      end else if (r == 0) begin : g_top
        assign tap_d = p2;
      end else if (r == 1) begin : g_mid
        assign tap_d = p1;
      end else begin : g_bot
        assign tap_d = in_data;
      end

      median_ce_reg #(.WIDTH(WIDTH)) u_tap (
        .clk (clk),
        .rst (rst),
        .ce  (accept),
        .d   (tap_d),
        .q   (win_q[r][c])
      );

      assign out_win[tap_offset(r, c, WIDTH) +: WIDTH] = win_q[r][c];
    end
  end

endmodule

// File: tb/tb_median_window_3x3.sv
// Scoreboard bench for median_window_3x3: a 4-pixel-line instance and a
// 3-pixel-line instance, directed raster streams with hand-derived windows.
module tb_median_window_3x3;
  import median_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_sof;
  logic [7:0]  in_data;
  logic        out_valid;
  logic [71:0] out_win;
  logic        in_valid3, in_sof3;
  logic [7:0]  in_data3;
  logic        out_valid3;
  logic [71:0] out_win3;

  int n_checks = 0;
  int n_fail   = 0;

  logic [71:0] exp_q  [$];
  logic [71:0] exp3_q [$];

  median_window_3x3 #(.WIDTH(8), .LINE_LEN(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_win   (out_win)
  );

  median_window_3x3 #(.WIDTH(8), .LINE_LEN(3)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_sof    (in_sof3),
    .in_data   (in_data3),
    .out_valid (out_valid3),
    .out_win   (out_win3)
  );

  always #5 clk = ~clk;

  // In a raster ramp, tap (r,c) of the window ending at pixel 'last' is
  // last - (2-r)*len - (2-c).
  function automatic logic [71:0] exp_win(input int last, input int len);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w[tap_offset(r, c, 8) +: 8] = 8'(last - (2 - r) * len - (2 - c));
      end
    end
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic applyStimulus(input bit sel3, input bit v, input bit sof, input logic [7:0] d,
                               input bit expect_win, input logic [71:0] win);
    if (sel3) begin
      in_valid3 = v; in_sof3 = sof; in_data3 = d;
      if (expect_win) exp3_q.push_back(win);
    end else begin
      in_valid = v; in_sof = sof; in_data = d;
      if (expect_win) exp_q.push_back(win);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sof = 1'b0;
    in_valid3 = 1'b0; in_sof3 = 1'b0;
  endtask

  // Monitors: every valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL unexpected_valid4: got window %h, expected no pulse", out_win);
      end else begin
        checkOutput("win4", out_win, exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (out_valid3 === 1'b1) begin
      if (exp3_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("[TB] FAIL unexpected_valid3: got window %h, expected no pulse", out_win3);
      end else begin
        checkOutput("win3", out_win3, exp3_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    in_valid3 = 1'b0; in_sof3 = 1'b0; in_data3 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_valid", {71'b0, out_valid}, 72'd0);
    checkOutput("reset_win", out_win, 72'd0);
    checkOutput("reset_win3", out_win3, 72'd0);
    rst = 1'b0;

    $display("[TB] continuous frame 1..16, then row 4 pixels 17..20");
    for (int p = 1; p <= 16; p++)
      applyStimulus(0, 1, p == 1, 8'(p), p == 11 || p == 12 || p == 15 || p == 16, exp_win(p, 4));
    for (int p = 17; p <= 20; p++)
      applyStimulus(0, 1, 0, 8'(p), p >= 19, exp_win(p, 4));
    applyStimulus(0, 0, 0, 8'h00, 0, '0);
    checkOutput("drain_continuous", 72'(exp_q.size()), 72'd0);

    $display("[TB] gapped frame 1..16");
    for (int p = 1; p <= 16; p++) begin
      bit is_win;
      is_win = (p == 11 || p == 12 || p == 15 || p == 16);
      applyStimulus(0, 1, p == 1, 8'(p), is_win, exp_win(p, 4));
      for (int g = 0; g < 2; g++) begin
        applyStimulus(0, 0, 1, 8'hAA, 0, '0);
        checkOutput("gap_valid", {71'b0, out_valid}, 72'd0);
        if (is_win) checkOutput("gap_hold", out_win, exp_win(p, 4));
      end
    end
    checkOutput("drain_gapped", 72'(exp_q.size()), 72'd0);

    $display("[TB] sof mid-line restart");
    for (int k = 1; k <= 6; k++)
      applyStimulus(0, 1, k == 1, 8'(100 + k), 0, '0);
    for (int n = 1; n <= 13; n++)
      applyStimulus(0, 1, n == 1, 8'(200 + n), n == 11 || n == 12, exp_win(200 + n, 4));
    applyStimulus(0, 0, 0, 8'h00, 0, '0);
    checkOutput("drain_midsof", 72'(exp_q.size()), 72'd0);

    $display("[TB] reset after pixel 10 with a pixel presented");
    for (int p = 1; p <= 10; p++)
      applyStimulus(0, 1, p == 1, 8'(p), 0, '0);
    rst = 1'b1; in_valid = 1'b1; in_sof = 1'b0; in_data = 8'hEE;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    checkOutput("rst_mid_valid", {71'b0, out_valid}, 72'd0);
    checkOutput("rst_mid_win", out_win, 72'd0);
    for (int p = 1; p <= 16; p++)
      applyStimulus(0, 1, 0, 8'(p), p == 11 || p == 12 || p == 15 || p == 16, exp_win(p, 4));
    applyStimulus(0, 0, 0, 8'h00, 0, '0);
    checkOutput("drain_after_rst", 72'(exp_q.size()), 72'd0);

    $display("[TB] LINE_LEN=3 all-FF and ramp frames");
    for (int p = 1; p <= 12; p++)
      applyStimulus(1, 1, p == 1, 8'hFF, p == 9 || p == 12, {9{8'hFF}});
    for (int p = 1; p <= 12; p++)
      applyStimulus(1, 1, p == 1, 8'(p), p == 9 || p == 12, exp_win(p, 3));
    applyStimulus(1, 0, 0, 8'h00, 0, '0);
    checkOutput("drain_len3", 72'(exp3_q.size()), 72'd0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
